// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding scheduler: select encoding,
// per-stage destination tag and the bubble constant.
package fwd_pkg;

  localparam int TAG_REG_W = 5;

  typedef enum logic [2:0] {
    FWD_RDAT       = 3'b000,
    FWD_EXMEM_ALU  = 3'b001,
    FWD_MEMWB_ALU  = 3'b010,
    FWD_EXMEM_UP16 = 3'b011,
    FWD_MEMWB_UP16 = 3'b100
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_REG_W-1:0] wsel;
    logic                 regwen;
    logic                 memtoreg;
    logic                 lui;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '{valid: 1'b0, wsel: '0, regwen: 1'b0,
                                        memtoreg: 1'b0, lui: 1'b0};

  function automatic logic tag_writes(stage_tag_t t, logic [TAG_REG_W-1:0] src);
    return t.valid & t.regwen & (t.wsel == src);
  endfunction

endpackage

// File: rtl/forward_sched_unit_if.sv
// ID-stage request and forwarding/stall response bundle of the scheduler.
interface forward_sched_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_wsel;
  logic             id_regwen;
  logic             id_memtoreg;
  logic             id_lui;
  logic [2:0]       forwarda;
  logic [2:0]       forwardb;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output freeze, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wsel, id_regwen, id_memtoreg, id_lui,
    input  forwarda, forwardb, stall, stall_cnt
  );

  modport slave (
    input  freeze, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wsel, id_regwen, id_memtoreg, id_lui,
    output forwarda, forwardb, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_sel_calc.sv
// Per-operand match against the EX and MEM tags: forward select for
// ALU/upper16 producers, load-use flag for load producers.
module fwd_sel_calc
  import fwd_pkg::*;
#(
  parameter int REG_W = TAG_REG_W
) (
  input  logic             id_valid,
  input  logic             uses,
  input  logic [REG_W-1:0] src,
  input  stage_tag_t       ex_tag,
  input  stage_tag_t       mem_tag,
  output fwd_sel_t         sel,
  output logic             load_hazard
);

  logic reads_src;
  logic match_ex;
  logic match_mem;

  assign reads_src   = id_valid & uses & (src != '0);
  assign match_ex    = reads_src & tag_writes(ex_tag, src);
  assign match_mem   = reads_src & tag_writes(mem_tag, src);
  assign load_hazard = (match_ex & ex_tag.memtoreg) | (match_mem & mem_tag.memtoreg);

  // Youngest producer wins; a load in EX shadows older MEM data (it stalls anyway).
  always_comb begin
    sel = FWD_RDAT;
    if (match_ex) begin
      if (!ex_tag.memtoreg) sel = ex_tag.lui ? FWD_EXMEM_UP16 : FWD_EXMEM_ALU;
    end else if (match_mem && !mem_tag.memtoreg) begin
      sel = mem_tag.lui ? FWD_MEMWB_UP16 : FWD_MEMWB_ALU;
    end
  end

endmodule

// File: rtl/forward_sched_unit.sv
// Forwarding scheduler: tracks EX/MEM destination tags, registers operand
// forward selects into EX and raises load-use stalls with a stall counter.
module forward_sched_unit
  import fwd_pkg::*;
#(
  parameter int REG_W = TAG_REG_W,
  parameter int CNT_W = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  forward_sched_unit_if.slave bus
);

  stage_tag_t       ex_tag_reg;
  stage_tag_t       mem_tag_reg;
  stage_tag_t       id_tag;
  fwd_sel_t         forwarda_reg;
  fwd_sel_t         forwardb_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  fwd_sel_t         sel_next [2];
  logic [REG_W-1:0] op_src   [2];
  logic             op_uses  [2];
  logic [1:0]       load_hazard;
  logic             stall;
  logic             bubble;

  assign op_src[0]  = bus.id_rs;
  assign op_src[1]  = bus.id_rt;
  assign op_uses[0] = bus.id_uses_rs;
  assign op_uses[1] = bus.id_uses_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      fwd_sel_calc #(.REG_W(REG_W)) u_calc (
        .id_valid    (bus.id_valid),
        .uses        (op_uses[gi]),
        .src         (op_src[gi]),
        .ex_tag      (ex_tag_reg),
        .mem_tag     (mem_tag_reg),
        .sel         (sel_next[gi]),
        .load_hazard (load_hazard[gi])
      );
    end
  endgenerate

  always_comb begin
    id_tag          = BUBBLE_TAG;
    id_tag.valid    = bus.id_valid;
    id_tag.wsel     = bus.id_wsel;
    id_tag.regwen   = bus.id_regwen;
    id_tag.memtoreg = bus.id_memtoreg;
    id_tag.lui      = bus.id_lui;
  end

  // A squashed ID instruction never stalls; its slot becomes a bubble instead.
  assign stall  = (|load_hazard) & ~bus.flush;
  assign bubble = stall | bus.flush | ~bus.id_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_tag_reg   <= BUBBLE_TAG;
      mem_tag_reg  <= BUBBLE_TAG;
      forwarda_reg <= FWD_RDAT;
      forwardb_reg <= FWD_RDAT;
    end else if (!bus.freeze) begin
      mem_tag_reg <= ex_tag_reg;
      if (bubble) begin
        ex_tag_reg   <= BUBBLE_TAG;
        forwarda_reg <= FWD_RDAT;
        forwardb_reg <= FWD_RDAT;
      end else begin
        ex_tag_reg   <= id_tag;
        forwarda_reg <= sel_next[0];
        forwardb_reg <= sel_next[1];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
    end else if (!bus.freeze && stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.forwarda  = forwarda_reg;
  assign bus.forwardb  = forwardb_reg;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_forward_sched_unit.sv
// Directed scoreboard bench for forward_sched_unit: the driver queues the
// expected outputs of every cycle, a negedge monitor pops and compares them.
module tb_forward_sched_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  typedef struct {
    string            name;
    logic [2:0]       fa;
    logic [2:0]       fb;
    logic             st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic nrst;
  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  forward_sched_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  forward_sched_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: reset released, 1: reset held low, 2: reset pulled low mid-cycle
  task automatic cyc(input string nm, input int mode, input bit frz, input bit fl,
                     input bit v, input int rs, input int rt, input bit urs, input bit urt,
                     input int ws, input bit rw, input bit mtr, input bit lui,
                     input int efa, input int efb, input bit est, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    nrst            = (mode == 1) ? 1'b0 : 1'b1;
    bus.freeze      = frz;
    bus.flush       = fl;
    bus.id_valid    = v;
    bus.id_rs       = REG_W'(rs);
    bus.id_rt       = REG_W'(rt);
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_wsel     = REG_W'(ws);
    bus.id_regwen   = rw;
    bus.id_memtoreg = mtr;
    bus.id_lui      = lui;
    e.name = nm;
    e.fa   = 3'(efa);
    e.fb   = 3'(efb);
    e.st   = est;
    e.cnt  = CNT_W'(ecnt);
    exp_q.push_back(e);
    if (mode == 2) begin
      #2;
      nrst = 1'b0;
    end
  endtask

  task automatic nop(input string nm, input int efa, input int efb, input bit est, input int ecnt);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efa, efb, est, ecnt);
  endtask

  // Monitor: every cycle with a queued expectation is one comparison.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks_total++;
        if (bus.forwarda !== e.fa || bus.forwardb !== e.fb ||
            bus.stall !== e.st || bus.stall_cnt !== e.cnt) begin
          $display("FAIL %s: got fa=%0d fb=%0d stall=%0b cnt=%0d, required fa=%0d fb=%0d stall=%0b cnt=%0d",
                   e.name, bus.forwarda, bus.forwardb, bus.stall, bus.stall_cnt,
                   e.fa, e.fb, e.st, e.cnt);
        end else begin
          checks_passed++;
          $display("ok   %s: fa=%0d fb=%0d stall=%0b cnt=%0d",
                   e.name, bus.forwarda, bus.forwardb, bus.stall, bus.stall_cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    bus.freeze = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_wsel = '0; bus.id_regwen = 0; bus.id_memtoreg = 0; bus.id_lui = 0;

    //  name                 md frz fl  v  rs rt urs urt ws rw mtr lui  fa fb st cnt
    cyc("reset_hold",         1, 0, 0,  1,  1, 2, 1, 1,  3, 1, 0, 0,   0, 0, 0, 0);
    // back-to-back ALU dependency
    cyc("add_r3",             0, 0, 0,  1,  1, 2, 1, 1,  3, 1, 0, 0,   0, 0, 0, 0);
    cyc("sub_rs_r3",          0, 0, 0,  1,  3, 1, 1, 1,  6, 1, 0, 0,   0, 0, 0, 0);
    nop("sub_ex_fwda_exmem",                                           1, 0, 0, 0);
    nop("bubble_in_ex",                                                0, 0, 0, 0);
    // distance-2 upper16 producer
    cyc("lui_r5",             0, 0, 0,  1,  0, 0, 0, 0,  5, 1, 0, 1,   0, 0, 0, 0);
    nop("lui_in_ex",                                                   0, 0, 0, 0);
    cyc("or_rt_r5",           0, 0, 0,  1,  2, 5, 1, 1,  7, 1, 0, 0,   0, 0, 0, 0);
    nop("or_ex_fwdb_memwb_up16",                                       0, 4, 0, 0);
    // load-use: two stall cycles
    cyc("lw_r4",              0, 0, 0,  1,  1, 0, 1, 0,  4, 1, 1, 0,   0, 0, 0, 0);
    cyc("use_r4_stall_ex",    0, 0, 0,  1,  4, 2, 1, 1,  8, 1, 0, 0,   0, 0, 1, 0);
    cyc("use_r4_stall_mem",   0, 0, 0,  1,  4, 2, 1, 1,  8, 1, 0, 0,   0, 0, 1, 1);
    nop("use_r4_ex_rdat",                                              0, 0, 0, 2);
    // freeze held during a load-use stall
    cyc("lw_r9",              0, 0, 0,  1,  1, 0, 1, 0,  9, 1, 1, 0,   0, 0, 0, 2);
    cyc("freeze_stall_1",     0, 1, 0,  1,  9, 9, 1, 1, 10, 1, 0, 0,   0, 0, 1, 2);
    cyc("freeze_stall_2",     0, 1, 0,  1,  9, 9, 1, 1, 10, 1, 0, 0,   0, 0, 1, 2);
    cyc("freeze_stall_3",     0, 1, 0,  1,  9, 9, 1, 1, 10, 1, 0, 0,   0, 0, 1, 2);
    cyc("unfreeze_stall_ex",  0, 0, 0,  1,  9, 9, 1, 1, 10, 1, 0, 0,   0, 0, 1, 2);
    cyc("unfreeze_stall_mem", 0, 0, 0,  1,  9, 9, 1, 1, 10, 1, 0, 0,   0, 0, 1, 3);
    nop("and_ex_after_freeze",                                         0, 0, 0, 4);
    // flush beats hazard; squashed instruction must not become a producer
    cyc("lw_r11",             0, 0, 0,  1,  1, 0, 1, 0, 11, 1, 1, 0,   0, 0, 0, 4);
    cyc("flush_over_hazard",  0, 0, 1,  1, 11,11, 1, 1, 12, 1, 0, 0,   0, 0, 0, 4);
    cyc("or_reads_flushed",   0, 0, 0,  1, 12, 0, 1, 1, 13, 1, 0, 0,   0, 0, 0, 4);
    nop("or_ex_no_fwd",                                                0, 0, 0, 4);
    // register 0 is never forwarded
    cyc("add_r0",             0, 0, 0,  1,  1, 2, 1, 1,  0, 1, 0, 0,   0, 0, 0, 4);
    cyc("sub_reads_r0",       0, 0, 0,  1,  0, 0, 1, 1, 14, 1, 0, 0,   0, 0, 0, 4);
    nop("r0_select_rdat",                                              0, 0, 0, 4);
    // remaining encodings: EX/MEM upper16 and MEM/WB ALU
    cyc("lui_r15",            0, 0, 0,  1,  0, 0, 0, 0, 15, 1, 0, 1,   0, 0, 0, 4);
    cyc("addu_r16",           0, 0, 0,  1, 15,20, 1, 1, 16, 1, 0, 0,   0, 0, 0, 4);
    cyc("xor_r17",            0, 0, 0,  1, 16,15, 1, 1, 17, 1, 0, 0,   3, 0, 0, 4);
    cyc("slt_r18",            0, 0, 0,  1, 16, 3, 1, 1, 18, 1, 0, 0,   1, 4, 0, 4);
    nop("slt_ex_memwb_alu",                                            2, 0, 0, 4);
    // same destination in EX and MEM: youngest wins
    cyc("add_r20_old",        0, 0, 0,  1,  1, 2, 1, 1, 20, 1, 0, 0,   0, 0, 0, 4);
    cyc("add_r20_new",        0, 0, 0,  1,  1, 2, 1, 1, 20, 1, 0, 0,   0, 0, 0, 4);
    cyc("sub_r20",            0, 0, 0,  1, 20,20, 1, 1, 22, 1, 0, 0,   0, 0, 0, 4);
    nop("youngest_wins",                                               1, 1, 0, 4);
    // counter saturation (3-bit counter)
    cyc("lw_r21",             0, 0, 0,  1,  1, 0, 1, 0, 21, 1, 1, 0,   0, 0, 0, 4);
    cyc("use_r21_rt_ex",      0, 0, 0,  1,  2,21, 1, 1, 23, 1, 0, 0,   0, 0, 1, 4);
    cyc("use_r21_rt_mem",     0, 0, 0,  1,  2,21, 1, 1, 23, 1, 0, 0,   0, 0, 1, 5);
    nop("cnt_six",                                                     0, 0, 0, 6);
    cyc("lw_r24",             0, 0, 0,  1,  1, 0, 1, 0, 24, 1, 1, 0,   0, 0, 0, 6);
    cyc("use_r24_ex",         0, 0, 0,  1, 24, 0, 1, 1, 25, 1, 0, 0,   0, 0, 1, 6);
    cyc("use_r24_mem",        0, 0, 0,  1, 24, 0, 1, 1, 25, 1, 0, 0,   0, 0, 1, 7);
    nop("cnt_saturated",                                               0, 0, 0, 7);
    // asynchronous reset with live selects and counter
    cyc("add_r26",            0, 0, 0,  1,  1, 2, 1, 1, 26, 1, 0, 0,   0, 0, 0, 7);
    cyc("sub_r26",            0, 0, 0,  1, 26,26, 1, 1, 27, 1, 0, 0,   0, 0, 0, 7);
    cyc("async_reset",        2, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);
    nop("after_reset",                                                 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks_total++;
      $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
